// File: rtl/button_press_decoder.sv
// Push-button front end: two-flop synchroniser, debounce FSM, and registered
// press/release/long-press pulses with a clean level and a wrapping press counter.
module button_press_decoder #(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int CNT_W           = 27,
    parameter int PCNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_in,
    output logic              btn_level,
    output logic              press_pulse,
    output logic              release_pulse,
    output logic              long_pulse,
    output logic [PCNT_W-1:0] press_count
);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    state_t             state;
    state_t             state_next;
    logic               s1;
    logic               s2;
    logic               btn_s;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   long_cnt;
    logic [CNT_W-1:0]   long_cnt_next;
    logic               long_flag;
    logic               long_flag_next;
    logic               level_next;
    logic               press_next;
    logic               release_next;
    logic               long_next;
    logic [PCNT_W-1:0]  count_next;

    assign btn_s = s2;

    // Every flop in the block lives here so that all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            state         <= IDLE;
            cnt           <= '0;
            long_cnt      <= '0;
            long_flag     <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= '0;
        end else begin
            s1            <= btn_in;
            s2            <= s1;
            state         <= state_next;
            cnt           <= cnt_next;
            long_cnt      <= long_cnt_next;
            long_flag     <= long_flag_next;
            btn_level     <= level_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            long_pulse    <= long_next;
            press_count   <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_next = DEB_PRESS;
                    cnt_next   = '0;
                end
            end
            DEB_PRESS: begin
                if (!btn_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_next = PRESSED;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_next = DEB_RELEASE;
                    cnt_next   = '0;
                end
            end
            DEB_RELEASE: begin
                if (btn_s) begin
                    state_next = PRESSED;
                end else if (cnt == DEB_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // The long-press timer keeps running through release bouncing and fires once per press.
    always_comb begin
        press_next     = (state == DEB_PRESS) && btn_s && (cnt == DEB_LAST);
        release_next   = (state == DEB_RELEASE) && !btn_s && (cnt == DEB_LAST);
        level_next     = (state_next == PRESSED) || (state_next == DEB_RELEASE);
        count_next     = press_next ? press_count + PCNT_W'(1) : press_count;
        long_cnt_next  = long_cnt;
        long_flag_next = long_flag;
        long_next      = 1'b0;
        if (press_next) begin
            long_cnt_next  = '0;
            long_flag_next = 1'b0;
        end else if (((state == PRESSED) || (state == DEB_RELEASE)) && !long_flag) begin
            if (long_cnt == LONG_LAST) begin
                long_next      = 1'b1;
                long_flag_next = 1'b1;
            end else begin
                long_cnt_next = long_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_button_press_decoder.sv
// Directed bench for button_press_decoder with short debounce/long-press timings;
// event edges are logged relative to the first edge that samples each new input level.
module tb_button_press_decoder;

    localparam int DEB    = 4;
    localparam int LONG   = 20;
    localparam int PCNT_W = 8;

    logic              clk;
    logic              rst_n;
    logic              btn_in;
    logic              btn_level;
    logic              press_pulse;
    logic              release_pulse;
    logic              long_pulse;
    logic [PCNT_W-1:0] press_count;

    int vectors;
    int miscompares;
    int cyc;
    int last_start;
    int n_press;
    int n_release;
    int n_long;
    int press_at;
    int release_at;
    int long_at;
    int overlap;
    logic level_low_seen;

    button_press_decoder #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG),
        .CNT_W          (27),
        .PCNT_W         (PCNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .press_count  (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic clearEvents();
        n_press        = 0;
        n_release      = 0;
        n_long         = 0;
        press_at       = -1;
        release_at     = -1;
        long_at        = -1;
        level_low_seen = 1'b0;
    endtask

    // Hold btn_in at val for n edges, logging pulses; edge 0 is the first edge that samples val.
    task automatic applyStimulus(input logic val, input int n);
        btn_in     = val;
        last_start = cyc + 1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (press_pulse) begin
                n_press++;
                press_at = cyc;
            end
            if (release_pulse) begin
                n_release++;
                release_at = cyc;
            end
            if (long_pulse) begin
                n_long++;
                long_at = cyc;
            end
            if (!btn_level) level_low_seen = 1'b1;
            if (press_pulse && release_pulse) overlap++;
        end
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        overlap     = 0;
        last_start  = 0;
        rst_n       = 1'b0;
        btn_in      = 1'b0;
        clearEvents();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_level", int'(btn_level), 0);
        checkOutput("rst_press", int'(press_pulse), 0);
        checkOutput("rst_release", int'(release_pulse), 0);
        checkOutput("rst_long", int'(long_pulse), 0);
        checkOutput("rst_count", int'(press_count), 0);
        rst_n = 1'b1;

        // Clean press
        clearEvents();
        applyStimulus(1'b1, 10);
        checkOutput("clean_npress", n_press, 1);
        checkOutput("clean_latency", press_at - last_start, DEB + 2);
        checkOutput("clean_level", int'(btn_level), 1);
        checkOutput("clean_count", int'(press_count), 1);

        // Asynchronous reset while held: outputs clear with no clock edge
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_level", int'(btn_level), 0);
        checkOutput("async_count", int'(press_count), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Button held through reset release counts as a fresh press
        clearEvents();
        applyStimulus(1'b1, 10);
        checkOutput("held_npress", n_press, 1);
        checkOutput("held_latency", press_at - last_start, DEB + 2);
        checkOutput("held_count", int'(press_count), 1);

        clearEvents();
        applyStimulus(1'b0, 10);
        checkOutput("rel_nrelease", n_release, 1);
        checkOutput("rel_latency", release_at - last_start, DEB + 2);
        checkOutput("rel_level", int'(btn_level), 0);
        checkOutput("rel_nlong", n_long, 0);

        // Press bounce never completes debouncing
        clearEvents();
        for (int r = 0; r < 5; r++) begin
            applyStimulus(1'b1, 2);
            applyStimulus(1'b0, 1);
        end
        checkOutput("bounce_npress", n_press, 0);
        checkOutput("bounce_count", int'(press_count), 1);
        applyStimulus(1'b1, 10);
        checkOutput("bounce_hold_npress", n_press, 1);
        checkOutput("bounce_hold_latency", press_at - last_start, DEB + 2);
        checkOutput("bounce_hold_count", int'(press_count), 2);

        // Release bounce keeps the level high
        clearEvents();
        for (int r = 0; r < 2; r++) begin
            applyStimulus(1'b0, 2);
            applyStimulus(1'b1, 1);
        end
        checkOutput("rbounce_nrelease", n_release, 0);
        checkOutput("rbounce_level_low", int'(level_low_seen), 0);
        applyStimulus(1'b0, 10);
        checkOutput("rbounce_rel_n", n_release, 1);
        checkOutput("rbounce_rel_latency", release_at - last_start, DEB + 2);
        checkOutput("rbounce_rel_level", int'(btn_level), 0);
        checkOutput("rbounce_nlong", n_long, 0);

        // Long press
        clearEvents();
        applyStimulus(1'b1, 40);
        checkOutput("long_npress", n_press, 1);
        checkOutput("long_n", n_long, 1);
        checkOutput("long_delay", long_at - press_at, LONG);
        checkOutput("long_count", int'(press_count), 3);
        clearEvents();
        applyStimulus(1'b0, 10);
        checkOutput("long_rel_n", n_release, 1);
        checkOutput("long_rel_nlong", n_long, 0);
        checkOutput("long_rel_npress", n_press, 0);

        // Counter wrap
        pulseReset();
        clearEvents();
        for (int p = 0; p < 255; p++) begin
            applyStimulus(1'b1, 8);
            applyStimulus(1'b0, 8);
        end
        checkOutput("wrap_count_255", int'(press_count), 255);
        checkOutput("wrap_npress_255", n_press, 255);
        applyStimulus(1'b1, 8);
        applyStimulus(1'b0, 8);
        checkOutput("wrap_count_0", int'(press_count), 0);
        checkOutput("wrap_npress_256", n_press, 256);
        checkOutput("wrap_nrelease_256", n_release, 256);

        checkOutput("press_release_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
